// File: rtl/rgb_fade_converter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_pkg
//  Brief    : Colour codes, fade FSM encoding and code->RGB palette helper.
//  Revision : 1.0  initial release
// ============================================================================
package rgb_pkg;

    typedef enum logic [2:0] {
        BLACK   = 3'd0,
        BLUE    = 3'd1,
        GREEN   = 3'd2,
        CYAN    = 3'd3,
        RED     = 3'd4,
        MAGENTA = 3'd5,
        YELLOW  = 3'd6,
        WHITE   = 3'd7
    } colour_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_e;

    // One flag per channel: set means that channel is driven to full scale.
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_sel_t;

    function automatic rgb_sel_t palette(input colour_e code);
        rgb_sel_t sel;
        sel.r = code[2];
        sel.g = code[1];
        sel.b = code[0];
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_fade_converter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_fade_converter_if
//  Brief    : Colour request in, faded RGB word and status out.
//  Revision : 1.0  initial release
// ============================================================================
interface rgb_fade_converter_if #(
    parameter int CH_W = 8
) ();

    logic              enable;
    logic [2:0]        colour;
    logic [3*CH_W-1:0] rgb;
    logic              busy;
    logic              done;

    modport master (
        output enable,
        output colour,
        input  rgb,
        input  busy,
        input  done
    );

    modport slave (
        input  enable,
        input  colour,
        output rgb,
        output busy,
        output done
    );

endinterface
`default_nettype wire

// File: rtl/rgb_fade_converter_ramp.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_channel_ramp
//  Brief    : One colour channel stepping toward its target by at most STEP.
//  Revision : 1.0  initial release
// ============================================================================
module rgb_channel_ramp #(
    parameter int CH_W = 8,
    parameter int STEP = 16
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            step_en,
    input  wire logic [CH_W-1:0] target,
    output logic      [CH_W-1:0] ch,
    output logic                 at_target
);

    localparam logic [CH_W-1:0] STEP_C = CH_W'(STEP);

    logic [CH_W-1:0] ch_q;
    logic [CH_W-1:0] ch_d;
    logic [CH_W:0]   diff;
    logic            up;
    logic [CH_W-1:0] mag;
    logic [CH_W-1:0] delta;
    logic [CH_W-1:0] ch_next;

    // Step is clamped to the remaining distance, so the ramp lands exactly.
    always_comb begin
        diff    = {1'b0, target} - {1'b0, ch_q};
        up      = ~diff[CH_W];
        mag     = up ? diff[CH_W-1:0] : (ch_q - target);
        delta   = (mag > STEP_C) ? STEP_C : mag;
        ch_next = up ? (ch_q + delta) : (ch_q - delta);
        ch_d    = step_en ? ch_next : ch_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q <= '0;
        end else begin
            ch_q <= ch_d;
        end
    end

    assign ch        = ch_q;
    // High when the channel will sit on its target once this step is taken.
    assign at_target = (ch_next == target);

endmodule
`default_nettype wire

// File: rtl/rgb_fade_converter.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_fade_converter
//  Brief    : Colour code to RGB word, fading toward each new colour in steps.
//  Revision : 1.0  initial release
// ============================================================================
module rgb_fade_converter
    import rgb_pkg::*;
#(
    parameter int CH_W     = 8,
    parameter int STEP     = 16,
    parameter int TICK_DIV = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    rgb_fade_converter_if.slave  bus
);

    localparam int              TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    state_e              state_q, state_d;
    logic [3*CH_W-1:0]   target_q, target_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    rgb_sel_t            sel;
    logic [3*CH_W-1:0]   pal;
    logic [3*CH_W-1:0]   rgb_cur;
    logic [2:0]          hits;
    logic                step;

    always_comb begin
        sel = palette(colour_e'(bus.colour));
        pal = {{CH_W{sel.r}}, {CH_W{sel.g}}, {CH_W{sel.b}}};
    end

    // Channel 2 is red (MSBs), channel 0 is blue (LSBs).
    for (genvar c = 0; c < 3; c++) begin : g_ch
        rgb_channel_ramp #(
            .CH_W (CH_W),
            .STEP (STEP)
        ) u_ramp (
            .clk       (clk),
            .rst_n     (rst_n),
            .step_en   (step),
            .target    (target_q[c*CH_W +: CH_W]),
            .ch        (rgb_cur[c*CH_W +: CH_W]),
            .at_target (hits[c])
        );
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        tick_d   = tick_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        step     = 1'b0;
        if (bus.enable) begin
            if (pal != target_q) begin
                target_d = pal;
                tick_d   = '0;
                // Retargeting onto the colour already shown ends the fade here.
                if (pal == rgb_cur) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = (state_q == FADE);
                end else begin
                    state_d = FADE;
                    busy_d  = 1'b1;
                end
            end else if (state_q == FADE) begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    step   = 1'b1;
                    if (&hits) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            tick_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            tick_q   <= tick_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.rgb  = rgb_cur;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_fade_converter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rgb_fade_converter
//  Brief    : Directed checks of fade sequences, retargeting, freeze and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rgb_fade_converter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    rgb_fade_converter_if #(.CH_W(8)) bus_a ();
    rgb_fade_converter_if #(.CH_W(4)) bus_b ();

    rgb_fade_converter #(.CH_W(8), .STEP(64), .TICK_DIV(2)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    rgb_fade_converter #(.CH_W(4), .STEP(15), .TICK_DIV(1)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_a(input string tag, input logic [23:0] rgb, input logic busy, input logic done);
        check({tag, " rgb"},  {8'h00, bus_a.rgb}, {8'h00, rgb});
        check({tag, " busy"}, {31'h0, bus_a.busy}, {31'h0, busy});
        check({tag, " done"}, {31'h0, bus_a.done}, {31'h0, done});
    endtask

    task automatic check_b(input string tag, input logic [11:0] rgb, input logic busy, input logic done);
        check({tag, " rgb"},  {20'h0, bus_b.rgb}, {20'h0, rgb});
        check({tag, " busy"}, {31'h0, bus_b.busy}, {31'h0, busy});
        check({tag, " done"}, {31'h0, bus_b.done}, {31'h0, done});
    endtask

    // Four-tick fade on DUT A; the colour must already be presented.
    task automatic fade4(input string tag, input logic [23:0] start,
                         input logic [23:0] s1, input logic [23:0] s2,
                         input logic [23:0] s3, input logic [23:0] s4);
        logic [23:0] seq [4];
        logic [23:0] prev;
        seq[0] = s1; seq[1] = s2; seq[2] = s3; seq[3] = s4;
        prev = start;
        cycles(1);
        check_a({tag, " sample"}, start, 1'b1, 1'b0);
        for (int s = 0; s < 4; s++) begin
            cycles(1);
            check_a($sformatf("%s hold%0d", tag, s), prev, 1'b1, 1'b0);
            cycles(1);
            check_a($sformatf("%s step%0d", tag, s), seq[s], (s < 3), (s == 3));
            prev = seq[s];
        end
        cycles(1);
        check_a({tag, " settle"}, s4, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n        = 1'b1;
        bus_a.enable = 1'b1;
        bus_a.colour = 3'd0;
        bus_b.enable = 1'b1;
        bus_b.colour = 3'd0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        cycles(2);
        check_a("reset", 24'h000000, 1'b0, 1'b0);
        check_b("reset_b", 12'h000, 1'b0, 1'b0);
        rst_n = 1'b1;
        cycles(1);
        check_a("post_reset", 24'h000000, 1'b0, 1'b0);

        bus_a.colour = 3'd4;
        fade4("t1", 24'h000000, 24'h400000, 24'h800000, 24'hC00000, 24'hFF0000);

        bus_a.colour = 3'd3;
        fade4("t2", 24'hFF0000, 24'hBF4040, 24'h7F8080, 24'h3FC0C0, 24'h00FFFF);

        bus_a.colour = 3'd0;
        fade4("t3a", 24'h00FFFF, 24'h00BFBF, 24'h007F7F, 24'h003F3F, 24'h000000);

        bus_a.colour = 3'd7;
        cycles(1); check_a("t3 sample", 24'h000000, 1'b1, 1'b0);
        cycles(1); check_a("t3 hold",   24'h000000, 1'b1, 1'b0);
        cycles(1); check_a("t3 tick",   24'h404040, 1'b1, 1'b0);
        bus_a.colour = 3'd0;
        cycles(1); check_a("t3 retarget", 24'h404040, 1'b1, 1'b0);
        cycles(1); check_a("t3 rhold",    24'h404040, 1'b1, 1'b0);
        cycles(1); check_a("t3 back",     24'h000000, 1'b0, 1'b1);
        cycles(1); check_a("t3 settle",   24'h000000, 1'b0, 1'b0);

        bus_a.colour = 3'd7;
        cycles(1); check_a("t3c sample", 24'h000000, 1'b1, 1'b0);
        bus_a.colour = 3'd0;
        cycles(1); check_a("t3c onrgb",  24'h000000, 1'b0, 1'b1);
        cycles(1); check_a("t3c settle", 24'h000000, 1'b0, 1'b0);
        cycles(3); check_a("t3c same",   24'h000000, 1'b0, 1'b0);

        bus_a.colour = 3'd4;
        cycles(1); check_a("t4 sample", 24'h000000, 1'b1, 1'b0);
        cycles(1); check_a("t4 hold",   24'h000000, 1'b1, 1'b0);
        cycles(1); check_a("t4 tick",   24'h400000, 1'b1, 1'b0);
        bus_a.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            check_a($sformatf("t4 frozen%0d", i), 24'h400000, 1'b1, 1'b0);
        end
        bus_a.enable = 1'b1;
        cycles(1); check_a("t4 r0", 24'h400000, 1'b1, 1'b0);
        cycles(1); check_a("t4 r1", 24'h800000, 1'b1, 1'b0);
        cycles(1); check_a("t4 r2", 24'h800000, 1'b1, 1'b0);
        cycles(1); check_a("t4 r3", 24'hC00000, 1'b1, 1'b0);
        cycles(1); check_a("t4 r4", 24'hC00000, 1'b1, 1'b0);
        cycles(1); check_a("t4 r5", 24'hFF0000, 1'b0, 1'b1);

        bus_a.colour = 3'd0;
        cycles(1); check_a("t5 sample", 24'hFF0000, 1'b1, 1'b0);
        cycles(1); check_a("t5 hold",   24'hFF0000, 1'b1, 1'b0);
        cycles(1); check_a("t5 tick",   24'hBF0000, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_a("t5 async", 24'h000000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1); check_a("t5 release", 24'h000000, 1'b0, 1'b0);

        bus_b.colour = 3'd7;
        cycles(1); check_b("t6 sample", 12'h000, 1'b1, 1'b0);
        cycles(1); check_b("t6 step",   12'hFFF, 1'b0, 1'b1);
        cycles(1); check_b("t6 settle", 12'hFFF, 1'b0, 1'b0);
        cycles(2); check_b("t6 same",   12'hFFF, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
